// File: rtl/pcie_reg_wr_arbiter.sv
// Round-robin arbiter sharing one PCIe requester register-write channel among
// NB_REQ clients. One write is in flight at a time, and a watchdog guards the
// downstream ack.
module pcie_reg_wr_arbiter #(
    parameter int unsigned NB_REQ         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned ADDR_W         = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       enable_i,
    input  logic [NB_REQ-1:0]          req_i,
    input  logic [NB_REQ*ADDR_W-1:0]   addr_i,
    input  logic [NB_REQ*32-1:0]       data_i,
    output logic [NB_REQ-1:0]          ack_o,
    output logic [NB_REQ-1:0]          err_o,
    output logic [ADDR_W-1:0]          nic_phys_addr_o,
    output logic [31:0]                nic_wr_data_o,
    output logic                       pcie_rq_start_o,
    input  logic                       pcie_rq_ack_i,
    output logic [$clog2(NB_REQ)-1:0]  grant_idx_o,
    output logic                       timeout_o,
    output logic [31:0]                wr_count_o
);

    localparam int unsigned IDX_W = $clog2(NB_REQ);
    localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          WD_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e              state_q,   state_d;
    logic [NB_REQ-1:0]   ack_q,     ack_d;
    logic [NB_REQ-1:0]   err_q,     err_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [31:0]         data_q,    data_d;
    logic                start_q,   start_d;
    logic [IDX_W-1:0]    grant_q,   grant_d;
    logic                timeout_q, timeout_d;
    logic [31:0]         count_q,   count_d;
    logic [WD_W-1:0]     wd_q,      wd_d;

    logic                win_found_c;
    logic [IDX_W-1:0]    win_idx_c;
    logic [IDX_W-1:0]    cand_c;

    // Round-robin search starting just after the last grant, wrapping around.
    always_comb begin
        win_found_c = 1'b0;
        win_idx_c   = grant_q;
        cand_c      = grant_q;
        for (int i = 1; i <= int'(NB_REQ); i++) begin
            cand_c = IDX_W'((int'(grant_q) + i) % int'(NB_REQ));
            if (!win_found_c && req_i[cand_c]) begin
                win_found_c = 1'b1;
                win_idx_c   = cand_c;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        ack_d     = '0;
        err_d     = '0;
        addr_d    = addr_q;
        data_d    = data_q;
        start_d   = start_q;
        grant_d   = grant_q;
        timeout_d = timeout_q;
        count_d   = count_q;
        wd_d      = wd_q;

        case (state_q)
            ST_IDLE: begin
                if (enable_i && win_found_c) begin
                    grant_d = win_idx_c;
                    addr_d  = addr_i[int'(win_idx_c)*int'(ADDR_W) +: ADDR_W];
                    data_d  = data_i[int'(win_idx_c)*32 +: 32];
                    start_d = 1'b1;
                    wd_d    = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (pcie_rq_ack_i) begin
                    // A real ack beats a watchdog expiry in the same cycle.
                    start_d = 1'b0;
                    ack_d   = NB_REQ'(1) << grant_q;
                    count_d = count_q + 32'd1;
                    state_d = ST_RELEASE;
                end else if (WD_EN && (wd_q == WD_LAST)) begin
                    start_d   = 1'b0;
                    ack_d     = NB_REQ'(1) << grant_q;
                    err_d     = NB_REQ'(1) << grant_q;
                    timeout_d = 1'b1;
                    state_d   = ST_RELEASE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_RELEASE: begin
                // One dead cycle so the served client can drop its request.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                start_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            ack_q     <= '0;
            err_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            start_q   <= 1'b0;
            grant_q   <= IDX_LAST;
            timeout_q <= 1'b0;
            count_q   <= '0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            start_q   <= start_d;
            grant_q   <= grant_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
            wd_q      <= wd_d;
        end
    end

    assign ack_o           = ack_q;
    assign err_o           = err_q;
    assign nic_phys_addr_o = addr_q;
    assign nic_wr_data_o   = data_q;
    assign pcie_rq_start_o = start_q;
    assign grant_idx_o     = grant_q;
    assign timeout_o       = timeout_q;
    assign wr_count_o      = count_q;

endmodule

// File: tb/tb_pcie_reg_wr_arbiter.sv
// Directed bench for pcie_reg_wr_arbiter (4 clients, 16-cycle watchdog).
module tb_pcie_reg_wr_arbiter;

    localparam int unsigned NB  = 4;
    localparam int unsigned AW  = 64;
    localparam int unsigned TMO = 16;

    logic            clk;
    logic            rst;
    logic            enable;
    logic [NB-1:0]   req;
    logic [NB*AW-1:0] addr;
    logic [NB*32-1:0] data;
    logic [NB-1:0]   ack;
    logic [NB-1:0]   err;
    logic [AW-1:0]   nic_addr;
    logic [31:0]     nic_data;
    logic            rq_start;
    logic            rq_ack;
    logic [1:0]      grant;
    logic            timeout;
    logic [31:0]     wr_count;

    int errors = 0;
    int checks = 0;

    pcie_reg_wr_arbiter #(
        .NB_REQ(NB), .TIMEOUT_CYCLES(TMO), .ADDR_W(AW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .req_i(req),
        .addr_i(addr), .data_i(data), .ack_o(ack), .err_o(err),
        .nic_phys_addr_o(nic_addr), .nic_wr_data_o(nic_data),
        .pcie_rq_start_o(rq_start), .pcie_rq_ack_i(rq_ack),
        .grant_idx_o(grant), .timeout_o(timeout), .wr_count_o(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; req = '0; rq_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; req = '0; rq_ack = 1'b0;
        tick(); tick();
        checks++; if (rq_start !== 1'b0 || ack !== 4'b0 || err !== 4'b0) begin
            errors++; $display("FAIL reset_ctl start=%b ack=%b err=%b exp 0/0000/0000", rq_start, ack, err); end
        checks++; if (grant !== 2'd3 || timeout !== 1'b0 || wr_count !== 32'd0) begin
            errors++; $display("FAIL reset_stat grant=%0d tmo=%b cnt=%0d exp 3/0/0", grant, timeout, wr_count); end
        checks++; if (nic_addr !== 64'd0 || nic_data !== 32'd0) begin
            errors++; $display("FAIL reset_bus addr=%h data=%h exp 0/0", nic_addr, nic_data); end
        rst = 1'b0; enable = 1'b1;
        // Requester ack with no write in flight must be ignored.
        rq_ack = 1'b1; tick(); tick(); rq_ack = 1'b0;
        checks++; if (ack !== 4'b0 || wr_count !== 32'd0 || rq_start !== 1'b0) begin
            errors++; $display("FAIL idle_ack ack=%b cnt=%0d start=%b exp 0000/0/0", ack, wr_count, rq_start); end
    endtask

    task automatic test_single_write();
        do_reset();
        req = 4'b0010;
        tick();
        checks++; if (rq_start !== 1'b1 || grant !== 2'd1) begin
            errors++; $display("FAIL single_start start=%b grant=%0d exp 1/1", rq_start, grant); end
        checks++; if (nic_addr !== 64'h0000_0000_F000_6018 || nic_data !== 32'd5) begin
            errors++; $display("FAIL single_bus addr=%h data=%h exp f0006018/5", nic_addr, nic_data); end
        tick(); tick(); tick();
        checks++; if (rq_start !== 1'b1 || ack !== 4'b0) begin
            errors++; $display("FAIL single_hold start=%b ack=%b exp 1/0000", rq_start, ack); end
        rq_ack = 1'b1;
        tick();
        rq_ack = 1'b0;
        checks++; if (ack !== 4'b0010 || err !== 4'b0 || rq_start !== 1'b0 || wr_count !== 32'd1) begin
            errors++; $display("FAIL single_ack ack=%b err=%b start=%b cnt=%0d exp 0010/0000/0/1", ack, err, rq_start, wr_count); end
        req = 4'b0000;
        tick();
        checks++; if (ack !== 4'b0 || grant !== 2'd1) begin
            errors++; $display("FAIL single_pulse ack=%b grant=%0d exp 0000/1", ack, grant); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [1:0] prev;
        do_reset();
        req = 4'b1111;
        prev = 2'd3;
        tick();
        for (int k = 0; k < 6; k++) begin
            checks++; if (rq_start !== 1'b1 || grant !== exp_g[k] || (k > 0 && grant === prev)) begin
                errors++; $display("FAIL rr_grant[%0d] start=%b grant=%0d exp 1/%0d", k, rq_start, grant, exp_g[k]); end
            prev = grant;
            tick();
            rq_ack = 1'b1;
            tick();
            rq_ack = 1'b0;
            checks++; if (ack !== (4'b0001 << exp_g[k])) begin
                errors++; $display("FAIL rr_ack[%0d] ack=%b exp %b", k, ack, 4'b0001 << exp_g[k]); end
            req[exp_g[k]] = 1'b0;
            tick();
            req[exp_g[k]] = 1'b1;
            tick();
        end
        rq_ack = 1'b1; tick(); rq_ack = 1'b0; req = '0; tick(); tick();
    endtask

    task automatic test_watchdog();
        do_reset();
        req = 4'b0100;
        tick();
        checks++; if (rq_start !== 1'b1 || grant !== 2'd2) begin
            errors++; $display("FAIL wd_start start=%b grant=%0d exp 1/2", rq_start, grant); end
        for (int k = 0; k < 15; k++) tick();
        checks++; if (rq_start !== 1'b1 || timeout !== 1'b0) begin
            errors++; $display("FAIL wd_early start=%b tmo=%b exp 1/0", rq_start, timeout); end
        tick();
        checks++; if (rq_start !== 1'b0 || ack !== 4'b0100 || err !== 4'b0100) begin
            errors++; $display("FAIL wd_fire start=%b ack=%b err=%b exp 0/0100/0100", rq_start, ack, err); end
        checks++; if (timeout !== 1'b1 || wr_count !== 32'd0) begin
            errors++; $display("FAIL wd_stat tmo=%b cnt=%0d exp 1/0", timeout, wr_count); end
        req = 4'b0000;
        tick();
        checks++; if (ack !== 4'b0 || err !== 4'b0 || timeout !== 1'b1) begin
            errors++; $display("FAIL wd_after ack=%b err=%b tmo=%b exp 0000/0000/1", ack, err, timeout); end
        req = 4'b0001;
        tick();
        checks++; if (rq_start !== 1'b1 || grant !== 2'd0) begin
            errors++; $display("FAIL wd_next_start start=%b grant=%0d exp 1/0", rq_start, grant); end
        rq_ack = 1'b1;
        tick();
        rq_ack = 1'b0; req = '0;
        checks++; if (ack !== 4'b0001 || err !== 4'b0 || wr_count !== 32'd1 || timeout !== 1'b1) begin
            errors++; $display("FAIL wd_next_ack ack=%b err=%b cnt=%0d tmo=%b exp 0001/0000/1/1", ack, err, wr_count, timeout); end
        tick();
    endtask

    task automatic test_collision();
        do_reset();
        req = 4'b1000;
        tick();
        for (int k = 0; k < 15; k++) tick();
        rq_ack = 1'b1;
        tick();
        rq_ack = 1'b0; req = '0;
        checks++; if (ack !== 4'b1000 || err !== 4'b0 || timeout !== 1'b0 || wr_count !== 32'd1) begin
            errors++; $display("FAIL collide ack=%b err=%b tmo=%b cnt=%0d exp 1000/0000/0/1", ack, err, timeout, wr_count); end
        tick();
    endtask

    task automatic test_gating();
        logic seen_start;
        do_reset();
        req = 4'b0011;
        tick();
        checks++; if (rq_start !== 1'b1 || grant !== 2'd0) begin
            errors++; $display("FAIL gate_start start=%b grant=%0d exp 1/0", rq_start, grant); end
        enable = 1'b0;
        tick();
        rq_ack = 1'b1;
        tick();
        rq_ack = 1'b0;
        checks++; if (ack !== 4'b0001 || wr_count !== 32'd1) begin
            errors++; $display("FAIL gate_finish ack=%b cnt=%0d exp 0001/1", ack, wr_count); end
        req = 4'b0010;
        seen_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (rq_start === 1'b1) seen_start = 1'b1;
        end
        checks++; if (seen_start !== 1'b0) begin
            errors++; $display("FAIL gate_hold start_seen=%b exp 0", seen_start); end
        enable = 1'b1;
        tick();
        checks++; if (rq_start !== 1'b1 || grant !== 2'd1 || nic_data !== 32'h1111_0001) begin
            errors++; $display("FAIL gate_resume start=%b grant=%0d data=%h exp 1/1/11110001", rq_start, grant, nic_data); end
        rq_ack = 1'b1; tick(); rq_ack = 1'b0; req = '0; tick();
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        req = 4'b0100;
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (rq_start !== 1'b0 || grant !== 2'd3 || nic_addr !== 64'd0) begin
            errors++; $display("FAIL async_rst start=%b grant=%0d addr=%h exp 0/3/0", rq_start, grant, nic_addr); end
        rq_ack = 1'b1;
        tick();
        rq_ack = 1'b0;
        checks++; if (ack !== 4'b0 || wr_count !== 32'd0) begin
            errors++; $display("FAIL rst_no_ack ack=%b cnt=%0d exp 0000/0", ack, wr_count); end
        req = 4'b0001;
        rst = 1'b0;
        tick();
        checks++; if (rq_start !== 1'b1 || grant !== 2'd0 || nic_addr !== 64'hAAAA_0000_0000_0000) begin
            errors++; $display("FAIL rst_regrant start=%b grant=%0d addr=%h exp 1/0/aaaa000000000000", rq_start, grant, nic_addr); end
        rq_ack = 1'b1; tick(); rq_ack = 1'b0; req = '0; tick();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; req = '0; rq_ack = 1'b0;
        addr = '0; data = '0;
        addr[0*AW +: AW] = 64'hAAAA_0000_0000_0000;
        addr[1*AW +: AW] = 64'h0000_0000_F000_6018;
        addr[2*AW +: AW] = 64'h0000_0002_0000_0020;
        addr[3*AW +: AW] = 64'h0000_0003_0000_0030;
        data[0*32 +: 32] = 32'h1111_0000;
        data[1*32 +: 32] = 32'd5;
        data[2*32 +: 32] = 32'h3333_0002;
        data[3*32 +: 32] = 32'h4444_0003;

        test_reset();
        test_single_write();
        data[1*32 +: 32] = 32'h1111_0001;
        test_round_robin();
        test_watchdog();
        test_collision();
        test_gating();
        test_reset_mid_write();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
